// File: rtl/sobel_bridge_pkg.sv
// Shared types and constants for the sobel AXI-Lite strobe/ack bridge.
package sobel_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RESP,
        ST_GAP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned GAP_CYCLES_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1 << 24;

endpackage

// File: rtl/sobel_axi_bridge_if.sv
// AXI4-Lite channel bundle between the processor and the sobel bridge.
interface sobel_axi_bridge_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sobel_axi_bridge_ack_sync.sv
// Toggle-ack receiver: 2-FF synchroniser, reference register and edge compare.
// Any change of the synchronised ack relative to the reference counts as seen.
module ack_toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ack_i,
    input  logic load_i,
    output logic seen_o
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic ref_q, ref_d;

    // Next-state for the synchroniser chain and the reference.
    always_comb begin
        sync1_d = ack_i;
        sync2_d = sync1_q;
        ref_d   = load_i ? sync2_q : ref_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            ref_q   <= ref_d;
        end
    end

    assign seen_o = sync2_q ^ ref_q;
endmodule

// File: rtl/sobel_axi_bridge.sv
// AXI4-Lite slave driving the sobel_top strobe/ack coefficient/histogram channel.
// Optional: define SOBEL_BRIDGE_ACK_TIMEOUT_EN to abort unanswered strobes with SLVERR.
module sobel_axi_bridge
    import sobel_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_axi_bridge_if.slave s_axi,
    output logic [ADDR_W-1:0] fir_addr_o,
    output logic [DATA_W-1:0] fir_coeff_o,
    output logic              wr_strobe_o,
    input  logic              wr_ack_i,
    output logic              rd_strobe_o,
    input  logic              rd_ack_i,
    input  logic [DATA_W-1:0] hist_bin_i,
    output logic              busy_o
);
    localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] fir_addr_q, fir_addr_d;
    logic [DATA_W-1:0] fir_coeff_q, fir_coeff_d;
    logic              wr_strobe_q, wr_strobe_d, rd_strobe_q, rd_strobe_d;
    logic              pref_rd_q, pref_rd_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              wr_load, rd_load, wr_seen, rd_seen;
    logic              in_req, grant_wr, grant_rd, timeout;

`ifdef SOBEL_BRIDGE_ACK_TIMEOUT_EN
    localparam logic [24:0] WAIT_LAST = 25'(TIMEOUT_CYCLES - 1);
    logic [24:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Read address is accepted for handshake only; the responder has one bin port.
    logic unused_araddr;
    assign unused_araddr = ^s_axi.araddr;

    ack_toggle_sync u_wr_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ack_i  (wr_ack_i),
        .load_i (wr_load),
        .seen_o (wr_seen)
    );

    ack_toggle_sync u_rd_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ack_i  (rd_ack_i),
        .load_i (rd_load),
        .seen_o (rd_seen)
    );

    // Transaction sequencing, arbitration and registered-output next state.
    always_comb begin
        state_d     = state_q;
        awready_d   = 1'b0;
        wready_d    = 1'b0;
        arready_d   = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        fir_addr_d  = fir_addr_q;
        fir_coeff_d = fir_coeff_q;
        wr_strobe_d = wr_strobe_q;
        rd_strobe_d = rd_strobe_q;
        pref_rd_d   = pref_rd_q;
        wr_load     = 1'b0;
        rd_load     = 1'b0;
        in_req      = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
        grant_wr    = s_axi.awvalid && s_axi.wvalid && (!s_axi.arvalid || !pref_rd_q);
        grant_rd    = s_axi.arvalid && !grant_wr;
        // Gap count restarts on the first cycle after a strobe drops.
        if (in_req)
            gap_cnt_d = '0;
        else if (gap_cnt_q != GAP_LAST)
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        else
            gap_cnt_d = gap_cnt_q;
`ifdef SOBEL_BRIDGE_ACK_TIMEOUT_EN
        wait_cnt_d = in_req ? wait_cnt_q + 25'd1 : '0;
        timeout    = (wait_cnt_q == WAIT_LAST);
`else
        timeout    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    awready_d   = 1'b1;
                    wready_d    = 1'b1;
                    fir_addr_d  = s_axi.awaddr;
                    fir_coeff_d = s_axi.wdata;
                    wr_strobe_d = 1'b1;
                    wr_load     = 1'b1;
                    pref_rd_d   = 1'b1;
                    state_d     = ST_WR_REQ;
                end else if (grant_rd) begin
                    arready_d   = 1'b1;
                    rd_strobe_d = 1'b1;
                    rd_load     = 1'b1;
                    pref_rd_d   = 1'b0;
                    state_d     = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (wr_seen || timeout) begin
                    wr_strobe_d = 1'b0;
                    bvalid_d    = 1'b1;
                    bresp_d     = wr_seen ? RESP_OKAY : RESP_SLVERR;
                    state_d     = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                if (rd_seen) begin
                    rd_strobe_d = 1'b0;
                    state_d     = ST_RD_CAP;
                end else if (timeout) begin
                    // Error response still needs its handshake, so it passes through RESP.
                    rd_strobe_d = 1'b0;
                    rvalid_d    = 1'b1;
                    rresp_d     = RESP_SLVERR;
                    rdata_d     = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RD_CAP: begin
                rdata_d  = hist_bin_i;
                rvalid_d = 1'b1;
                rresp_d  = RESP_OKAY;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if ((bvalid_q && s_axi.bready) || (rvalid_q && s_axi.rready)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SOBEL_BRIDGE_ACK_TIMEOUT_EN
        // Track the ack while idle so a late toggle from an aborted request is absorbed.
        if (state_q == ST_IDLE || state_q == ST_GAP) begin
            wr_load = 1'b1;
            rd_load = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            fir_addr_q  <= '0;
            fir_coeff_q <= '0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            pref_rd_q   <= 1'b0;
            gap_cnt_q   <= '0;
`ifdef SOBEL_BRIDGE_ACK_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            fir_addr_q  <= fir_addr_d;
            fir_coeff_q <= fir_coeff_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            pref_rd_q   <= pref_rd_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef SOBEL_BRIDGE_ACK_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.arready = arready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign fir_addr_o    = fir_addr_q;
    assign fir_coeff_o   = fir_coeff_q;
    assign wr_strobe_o   = wr_strobe_q;
    assign rd_strobe_o   = rd_strobe_q;
    assign busy_o        = (state_q != ST_IDLE);
endmodule
